// File: rtl/booth8_iter_mult.sv
// Iterative radix-8 Booth mantissa multiplier.
// Restores hidden bits, precomputes 3M once, then adds one Booth-selected
// partial product per cycle over nine digits. The result is returned over
// a valid/ready handshake.
module booth8_iter_mult #(
    parameter int unsigned MW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MW-2:0]   a_frac,
    input  logic [MW-2:0]   b_frac,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*MW-1:0] prod,
    output logic            busy
);

    localparam int unsigned AccW  = 2 * MW + 3;  // headroom for negative intermediates
    localparam int unsigned MagW  = MW + 3;      // wide enough for 4M
    localparam int unsigned QextW = MW + 4;      // q[26:24]=0 plus q[-1]=0
    localparam int unsigned NumDigits = 9;

    typedef enum logic [1:0] {StIdle, StPre, StAcc, StDone} state_e;

    typedef enum logic [2:0] {SelZero, SelM1, SelM2, SelM3, SelM4} sel_e;

    state_e           state_q, state_d;
    logic [MW-1:0]    m_q, m_d;
    logic [MW-1:0]    q_q, q_d;
    logic [MW+1:0]    m3_q, m3_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [3:0]       idx_q, idx_d;

    logic [5:0]       shamt;
    logic [QextW-1:0] qext;
    logic [3:0]       trip;
    sel_e             sel;
    logic             neg;
    logic [MagW-1:0]  mag;
    logic [AccW-1:0]  pp;
    logic [AccW-1:0]  pp_sh;

    // Booth recoding of the current digit and partial-product selection
    always_comb begin
        shamt = 6'({2'b00, idx_q} * 6'd3);
        qext  = {3'b000, q_q, 1'b0};
        trip  = 4'(qext >> shamt);
        sel   = SelZero;
        neg   = 1'b0;
        unique case (trip)
            4'b0000: sel = SelZero;
            4'b0001: sel = SelM1;
            4'b0010: sel = SelM1;
            4'b0011: sel = SelM2;
            4'b0100: sel = SelM2;
            4'b0101: sel = SelM3;
            4'b0110: sel = SelM3;
            4'b0111: sel = SelM4;
            4'b1000: begin sel = SelM4; neg = 1'b1; end
            4'b1001: begin sel = SelM3; neg = 1'b1; end
            4'b1010: begin sel = SelM3; neg = 1'b1; end
            4'b1011: begin sel = SelM2; neg = 1'b1; end
            4'b1100: begin sel = SelM2; neg = 1'b1; end
            4'b1101: begin sel = SelM1; neg = 1'b1; end
            4'b1110: begin sel = SelM1; neg = 1'b1; end
            4'b1111: sel = SelZero;
            default: sel = SelZero;
        endcase
        mag = '0;
        case (sel)
            SelM1:   mag = {3'b000, m_q};
            SelM2:   mag = {2'b00, m_q, 1'b0};
            SelM3:   mag = {1'b0, m3_q};
            SelM4:   mag = {1'b0, m_q, 2'b00};
            default: mag = '0;
        endcase
        pp    = neg ? (AccW'(0) - AccW'(mag)) : AccW'(mag);
        pp_sh = pp << shamt;
    end

    // Next-state, datapath updates and decoded outputs
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        m3_d      = m3_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        prod      = acc_q[2*MW-1:0];
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    m_d     = {1'b1, a_frac};
                    q_d     = {1'b1, b_frac};
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StPre;
                end
            end
            StPre: begin
                m3_d    = {2'b00, m_q} + {1'b0, m_q, 1'b0};
                state_d = StAcc;
            end
            StAcc: begin
                acc_d = acc_q + pp_sh;
                if (idx_q == 4'(NumDigits - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            q_q     <= '0;
            m3_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            m3_q    <= m3_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_booth8_iter_mult.sv
// Directed and random checks for booth8_iter_mult.
module tb_booth8_iter_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] prod;
    logic        busy;

    int errors;
    int checks;
    int lat;

    booth8_iter_mult #(.MW(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_frac    (a_frac),
        .b_frac    (b_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] ref_prod(input logic [22:0] a, input logic [22:0] b);
        logic [47:0] ma;
        logic [47:0] mb;
        ma = {24'd0, 1'b1, a};
        mb = {24'd0, 1'b1, b};
        return ma * mb;
    endfunction

    // Called #1 after an edge; returns #1 after the acceptance edge.
    task automatic send(input logic [22:0] a, input logic [22:0] b);
        chk("in_ready_before_send", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a_frac   = a;
        b_frac   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_frac   = 23'h5A5A5A;  // later input changes must not matter
        b_frac   = 23'h2B2B2B;
    endtask

    // Counts edges until out_valid is seen, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One full operation with immediate consumption.
    task automatic run_op(input string tag, input logic [22:0] a, input logic [22:0] b,
                          input logic [47:0] exp);
        int c;
        send(a, b);
        wait_out(c);
        chk({tag, "_latency"}, 64'(c), 64'd10);
        chk({tag, "_prod"}, {16'd0, prod}, {16'd0, exp});
        chk({tag, "_acc_hi"}, {61'd0, dut.acc_q[50:48]}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_frac    = '0;
        b_frac    = '0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_prod", {16'd0, prod}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero fractions with back-pressure
        send(23'd0, 23'd0);
        chk("zero_busy_pre", {63'd0, busy}, 64'd1);
        wait_out(lat);
        chk("zero_latency", 64'(lat), 64'd10);
        chk("zero_prod", {16'd0, prod}, 64'h4000_0000_0000);
        chk("zero_out_valid", {63'd0, out_valid}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a_frac   = 23'h7FFFFF;
            b_frac   = 23'h123456;
            @(posedge clk);
            #1;
            chk("bp_prod", {16'd0, prod}, 64'h4000_0000_0000);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);

        run_op("ones", 23'h7FFFFF, 23'h7FFFFF, 48'hFFFF_FE00_0001);
        run_op("neg4", 23'h000000, 23'h000004, 48'h4000_0200_0000);
        run_op("m3", 23'h400000, 23'h000003, 48'h6000_0240_0000);
        run_op("mixed", 23'h2AAAAA, 23'h555555, ref_prod(23'h2AAAAA, 23'h555555));

        // out_ready already high when out_valid rises: DONE lasts one cycle
        out_ready = 1'b1;
        send(23'h000001, 23'h000001);
        wait_out(lat);
        chk("early_ready_latency", 64'(lat), 64'd10);
        chk("early_ready_prod", {16'd0, prod}, 64'h4000_0100_0001);
        @(posedge clk);
        #1;
        chk("early_ready_done_1cyc", {63'd0, out_valid}, 64'd0);
        chk("early_ready_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;

        // Reset during ACC step 4
        send(23'h7FFFFF, 23'h7FFFFF);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_prod", {16'd0, prod}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_rst", 23'd0, 23'd0, 48'h4000_0000_0000);

        // Random back-to-back operands with random stalls
        for (int n = 0; n < 300; n++) begin
            logic [22:0] ra;
            logic [22:0] rb;
            int          stall;
            ra    = 23'($urandom);
            rb    = 23'($urandom);
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            send(ra, rb);
            wait_out(lat);
            chk("rand_latency", 64'(lat), 64'd10);
            chk("rand_prod", {16'd0, prod}, {16'd0, ref_prod(ra, rb)});
            for (int s = 1; s < stall; s++) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("rand_in_ready", {63'd0, in_ready}, 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
